morse_keyer: RTL and testbench

MORSE_KEYER -- requirements
Module: morse_keyer

---
 rtl/morse_keyer.sv | 182 ++++++++++++++++++
 tb/tb_morse_keyer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/morse_keyer.sv
// Morse keyer: synchronizes and debounces a raw key, classifies each press
// as a dot or a line by its length, and closes a letter after a long
// enough release. All outputs are registered.
module morse_keyer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DOT_MAX_CYCLES  = 12500000,
  parameter int GAP_CYCLES      = 25000000,
  parameter int MAX_SYMBOLS     = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_in,
  output logic       key_down,
  output logic       ld_dot,
  output logic       ld_line,
  output logic       letter_done,
  output logic [2:0] symbol_count,
  output logic       overflow
);

  localparam int DebW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PressW = $clog2(DOT_MAX_CYCLES + 1);
  localparam int GapW   = $clog2(GAP_CYCLES + 1);

  localparam logic [DebW-1:0]   DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PressW-1:0] PressMax = PressW'(DOT_MAX_CYCLES);
  localparam logic [GapW-1:0]   GapMax   = GapW'(GAP_CYCLES);
  localparam logic [2:0]        SymMax   = 3'(MAX_SYMBOLS);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    GAP
  } state_t;

  logic              syncMeta_q;
  logic              syncKey_q;
  logic [DebW-1:0]   debCnt_q,   debCnt_d;
  logic              keyDown_q,  keyDown_d;
  state_t            state_q,    state_d;
  logic [PressW-1:0] pressCnt_q, pressCnt_d;
  logic [GapW-1:0]   gapCnt_q,   gapCnt_d;
  logic [2:0]        symCnt_q,   symCnt_d;
  logic              ovf_q,      ovf_d;
  logic              dot_q,      dot_d;
  logic              line_q,     line_d;
  logic              done_q,     done_d;
  logic [PressW-1:0] pressInc;
  logic [GapW-1:0]   gapInc;

  // Two-flop synchronizer: the raw key is asynchronous to the clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncMeta_q <= 1'b0;
      syncKey_q  <= 1'b0;
    end else begin
      syncMeta_q <= key_in;
      syncKey_q  <= syncMeta_q;
    end
  end

  // Debounce: accept a new level only after it has held for the full run of edges.
  always_comb begin
    debCnt_d  = '0;
    keyDown_d = keyDown_q;
    if (syncKey_q != keyDown_q) begin
      if (debCnt_q == DebLast) begin
        keyDown_d = syncKey_q;
        debCnt_d  = '0;
      end else begin
        debCnt_d = debCnt_q + DebW'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      debCnt_q  <= '0;
      keyDown_q <= 1'b0;
    end else begin
      debCnt_q  <= debCnt_d;
      keyDown_q <= keyDown_d;
    end
  end

  // Keyer FSM next state: the press length seen on the release edge includes that edge.
  always_comb begin
    state_d    = state_q;
    pressCnt_d = pressCnt_q;
    gapCnt_d   = gapCnt_q;
    symCnt_d   = symCnt_q;
    ovf_d      = ovf_q;
    dot_d      = 1'b0;
    line_d     = 1'b0;
    done_d     = 1'b0;
    pressInc   = (pressCnt_q == PressMax) ? PressMax : pressCnt_q + PressW'(1);
    gapInc     = (gapCnt_q == GapMax) ? GapMax : gapCnt_q + GapW'(1);

    case (state_q)
      IDLE: begin
        if (keyDown_q) begin
          state_d    = PRESSED;
          pressCnt_d = '0;
        end
      end

      PRESSED: begin
        if (keyDown_q) begin
          pressCnt_d = pressInc;
        end else begin
          if (symCnt_q == SymMax) begin
            ovf_d = 1'b1;
          end else begin
            symCnt_d = symCnt_q + 3'd1;
            if (pressInc == PressMax) begin
              line_d = 1'b1;
            end else begin
              dot_d = 1'b1;
            end
          end
          state_d    = GAP;
          gapCnt_d   = '0;
          pressCnt_d = '0;
        end
      end

      GAP: begin
        if (keyDown_q) begin
          state_d    = PRESSED;
          pressCnt_d = '0;
          gapCnt_d   = '0;
        end else if (gapInc == GapMax) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          symCnt_d = '0;
          ovf_d    = 1'b0;
          gapCnt_d = '0;
        end else begin
          gapCnt_d = gapInc;
        end
      end

      default: begin
        state_d    = IDLE;
        pressCnt_d = '0;
        gapCnt_d   = '0;
      end
    endcase
  end

  // Keyer FSM state, counters and registered output pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pressCnt_q <= '0;
      gapCnt_q   <= '0;
      symCnt_q   <= '0;
      ovf_q      <= 1'b0;
      dot_q      <= 1'b0;
      line_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pressCnt_q <= pressCnt_d;
      gapCnt_q   <= gapCnt_d;
      symCnt_q   <= symCnt_d;
      ovf_q      <= ovf_d;
      dot_q      <= dot_d;
      line_q     <= line_d;
      done_q     <= done_d;
    end
  end

  assign key_down     = keyDown_q;
  assign ld_dot       = dot_q;
  assign ld_line      = line_q;
  assign letter_done  = done_q;
  assign symbol_count = symCnt_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Testbench for morse_keyer with small parameters: a table of press/release
// rows plus hand-written sequences for exact timing and reset corners.
module tb_morse_keyer;

  logic       clock;
  logic       reset;
  logic       keyIn;
  logic       keyDown;
  logic       ldDot;
  logic       ldLine;
  logic       letterDone;
  logic [2:0] symbolCount;
  logic       overflow;

  int checkCount;
  int passCount;

  int dotSeen;
  int lineSeen;
  int doneSeen;
  int bothSeen;
  int kdSeen;
  int countAtDone;
  int ovfAtDone;
  int countBeforeDone;
  int lastCount;

  typedef struct {
    int pressLen;
    int relLen;
    int expDot;
    int expLine;
    int expDone;
    int expCount;
    int expOvf;
  } row_t;

  row_t rows[7];

  morse_keyer #(
    .DEBOUNCE_CYCLES(4),
    .DOT_MAX_CYCLES (10),
    .GAP_CYCLES     (20),
    .MAX_SYMBOLS    (5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key_in      (keyIn),
    .key_down    (keyDown),
    .ld_dot      (ldDot),
    .ld_line     (ldLine),
    .letter_done (letterDone),
    .symbol_count(symbolCount),
    .overflow    (overflow)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Zero the pulse monitor before a measured window.
  task automatic clearMon();
    dotSeen         = 0;
    lineSeen        = 0;
    doneSeen        = 0;
    bothSeen        = 0;
    kdSeen          = 0;
    countAtDone     = -1;
    ovfAtDone       = -1;
    countBeforeDone = -1;
  endtask

  // Advance one clock and sample outputs on the following falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    if (ldDot) dotSeen++;
    if (ldLine) lineSeen++;
    if (ldDot && ldLine) bothSeen++;
    if (keyDown) kdSeen++;
    if (letterDone) begin
      doneSeen++;
      countAtDone     = int'(symbolCount);
      ovfAtDone       = int'(overflow);
      countBeforeDone = lastCount;
    end
    lastCount = int'(symbolCount);
  endtask

  // Hold the raw key at a level for a number of cycles.
  task automatic applyStimulus(input logic level, input int cycles);
    keyIn = level;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // Synchronous-looking reset pulse used to start each scenario cleanly.
  task automatic doReset();
    keyIn = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic int allOutputs();
    return int'({keyDown, ldDot, ldLine, letterDone, overflow, symbolCount});
  endfunction

  initial begin
    checkCount = 0;
    passCount  = 0;
    lastCount  = 0;
    keyIn      = 1'b0;
    reset      = 1'b1;
    clearMon();

    rows[0] = '{pressLen: 6,  relLen: 8,  expDot: 1, expLine: 0, expDone: 0, expCount: 1, expOvf: 0};
    rows[1] = '{pressLen: 15, relLen: 8,  expDot: 0, expLine: 1, expDone: 0, expCount: 2, expOvf: 0};
    rows[2] = '{pressLen: 4,  relLen: 8,  expDot: 1, expLine: 0, expDone: 0, expCount: 3, expOvf: 0};
    rows[3] = '{pressLen: 10, relLen: 8,  expDot: 0, expLine: 1, expDone: 0, expCount: 4, expOvf: 0};
    rows[4] = '{pressLen: 9,  relLen: 8,  expDot: 1, expLine: 0, expDone: 0, expCount: 5, expOvf: 0};
    rows[5] = '{pressLen: 5,  relLen: 8,  expDot: 0, expLine: 0, expDone: 0, expCount: 5, expOvf: 1};
    rows[6] = '{pressLen: 0,  relLen: 30, expDot: 0, expLine: 0, expDone: 1, expCount: 0, expOvf: 0};

    @(negedge clock);

    // Reset held while the key toggles: everything stays at zero.
    for (int i = 0; i < 8; i++) begin
      keyIn = i[0];
      tick();
      checkOutput("reset_outputs", allOutputs(), 0);
    end
    reset = 1'b0;
    keyIn = 1'b0;
    tick();

    // A 3-cycle glitch never gets through the debouncer.
    clearMon();
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 10);
    checkOutput("glitch_key_down", kdSeen, 0);
    checkOutput("glitch_dot", dotSeen, 0);
    checkOutput("glitch_line", lineSeen, 0);

    // Table of presses forming one letter with a dropped sixth symbol.
    doReset();
    for (int r = 0; r < 7; r++) begin
      clearMon();
      if (rows[r].pressLen > 0) applyStimulus(1'b1, rows[r].pressLen);
      applyStimulus(1'b0, rows[r].relLen);
      checkOutput($sformatf("row%0d_dot", r), dotSeen, rows[r].expDot);
      checkOutput($sformatf("row%0d_line", r), lineSeen, rows[r].expLine);
      checkOutput($sformatf("row%0d_done", r), doneSeen, rows[r].expDone);
      checkOutput($sformatf("row%0d_count", r), int'(symbolCount), rows[r].expCount);
      checkOutput($sformatf("row%0d_ovf", r), int'(overflow), rows[r].expOvf);
      checkOutput($sformatf("row%0d_both", r), bothSeen, 0);
    end
    checkOutput("done_count_same_edge", countAtDone, 0);
    checkOutput("done_count_before", countBeforeDone, 5);
    checkOutput("done_ovf_cleared", ovfAtDone, 0);

    // Exact timing of one dot and the letter close that follows it.
    doReset();
    applyStimulus(1'b1, 5);
    checkOutput("rise_not_yet", int'(keyDown), 0);
    applyStimulus(1'b1, 1);
    checkOutput("rise_on_time", int'(keyDown), 1);
    applyStimulus(1'b0, 6);
    checkOutput("fall_on_time", int'(keyDown), 0);
    checkOutput("dot_not_yet", int'(ldDot), 0);
    applyStimulus(1'b0, 1);
    checkOutput("dot_pulse", int'({ldDot, ldLine}), 2);
    checkOutput("dot_count", int'(symbolCount), 1);
    applyStimulus(1'b0, 1);
    checkOutput("dot_one_cycle", int'(ldDot), 0);
    applyStimulus(1'b0, 18);
    checkOutput("gap_not_yet", int'(letterDone), 0);
    checkOutput("gap_count_held", int'(symbolCount), 1);
    applyStimulus(1'b0, 1);
    checkOutput("gap_done_pulse", int'(letterDone), 1);
    checkOutput("gap_count_cleared", int'(symbolCount), 0);
    applyStimulus(1'b0, 1);
    checkOutput("gap_done_one_cycle", int'(letterDone), 0);
    clearMon();
    applyStimulus(1'b0, 40);
    checkOutput("idle_no_done", doneSeen, 0);

    // Reset in the middle of a press discards the symbol.
    doReset();
    applyStimulus(1'b1, 12);
    checkOutput("midpress_key_down", int'(keyDown), 1);
    reset = 1'b1;
    keyIn = 1'b0;
    #1;
    checkOutput("async_reset_outputs", allOutputs(), 0);
    applyStimulus(1'b0, 2);
    reset = 1'b0;
    clearMon();
    applyStimulus(1'b0, 30);
    checkOutput("midpress_no_dot", dotSeen, 0);
    checkOutput("midpress_no_line", lineSeen, 0);
    checkOutput("midpress_no_done", doneSeen, 0);
    checkOutput("midpress_count", int'(symbolCount), 0);

    // A key held through reset is debounced again from scratch.
    doReset();
    applyStimulus(1'b1, 10);
    reset = 1'b1;
    #1;
    checkOutput("held_reset_key_down", int'(keyDown), 0);
    applyStimulus(1'b1, 2);
    reset = 1'b0;
    applyStimulus(1'b1, 5);
    checkOutput("redebounce_not_yet", int'(keyDown), 0);
    applyStimulus(1'b1, 1);
    checkOutput("redebounce_rise", int'(keyDown), 1);
    clearMon();
    applyStimulus(1'b0, 30);
    checkOutput("redebounce_dot", dotSeen, 1);
    checkOutput("redebounce_line", lineSeen, 0);
    checkOutput("redebounce_done", doneSeen, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
